// File: rtl/pri_write_scheduler.sv
// pri_write_scheduler: queues CPU writes to the priority mixer control registers and replays
// them only on a vblank rising edge; keeps a shadow copy of every register for readback.
module pri_write_scheduler #(
   parameter int DEPTH = 8,
   parameter int NREG  = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cs,
   input  logic                     cpu_rw,
   input  logic [3:0]               cpu_addr,
   input  logic [15:0]              cpu_din,
   input  logic [1:0]               cpu_ds_n,
   output logic [15:0]              cpu_dout,
   input  logic                     vblank,
   output logic                     mix_we,
   output logic [3:0]               mix_addr,
   output logic [7:0]               mix_data,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     overflow,
   input  logic                     overflow_clr,
   output logic                     draining
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state, next_state;
   logic [11:0]   mem [DEPTH];
   logic [7:0]    shadow [NREG];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] drain_cnt;
   logic          vblank_q, wr_req, full, pop, push, vbl_rise;
   logic          unused;
   assign unused   = &{1'b0, cpu_din[15:8], cpu_ds_n[1]};
   assign wr_req   = cs & ~cpu_rw & ~cpu_ds_n[0];
   assign full     = pending == PW'(DEPTH);
   assign pop      = state == DRAIN;
   // a full FIFO still accepts a push when it pops on the same edge
   assign push     = wr_req & (~full | pop);
   assign vbl_rise = vblank & ~vblank_q;
   assign draining = pop;
   always_comb begin
      next_state = state;
      if (state == IDLE && vbl_rise && pending != '0)
         next_state = DRAIN;
      else if (state == DRAIN && drain_cnt == PW'(1))
         next_state = IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {cpu_addr, cpu_din[7:0]};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pending   <= '0;
         drain_cnt <= '0;
         vblank_q  <= 1'b0;
         mix_we    <= 1'b0;
         mix_addr  <= '0;
         mix_data  <= '0;
         overflow  <= 1'b0;
         cpu_dout  <= '0;
         for (int i = 0; i < NREG; i++) shadow[i] <= '0;
      end else begin
         vblank_q <= vblank;
         mix_we   <= pop;
         pending  <= pending + PW'(push) - PW'(pop);
         // set wins over clear
         overflow <= (wr_req & full & ~pop) | (overflow & ~overflow_clr);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr               <= rd_ptr + AW'(1);
            {mix_addr, mix_data} <= mem[rd_ptr];
         end
         // only entries present at the vblank edge are drained
         if (state == IDLE && vbl_rise) drain_cnt <= pending;
         else if (pop)                  drain_cnt <= drain_cnt - PW'(1);
         if (wr_req)        shadow[cpu_addr] <= cpu_din[7:0];
         if (cs & cpu_rw)   cpu_dout <= {2{shadow[cpu_addr]}};
      end
   end
endmodule

// File: tb/tb_pri_write_scheduler.sv
// tb_pri_write_scheduler: directed plus randomized stimulus checked every cycle against a
// queue-based model of the deferred-write scheduler.
module tb_pri_write_scheduler;
   localparam int DEPTH = 8;
   logic        clk = 0, reset_n = 0, cs = 0, cpu_rw = 1, vblank = 0, overflow_clr = 0;
   logic [3:0]  cpu_addr = 0;
   logic [15:0] cpu_din = 0;
   logic [1:0]  cpu_ds_n = 2'b11;
   logic [15:0] cpu_dout;
   logic        mix_we, overflow, draining;
   logic [3:0]  mix_addr;
   logic [7:0]  mix_data;
   logic [3:0]  pending;
   pri_write_scheduler #(.DEPTH(DEPTH), .NREG(16)) dut (
      .clk(clk), .reset_n(reset_n), .cs(cs), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr),
      .cpu_din(cpu_din), .cpu_ds_n(cpu_ds_n), .cpu_dout(cpu_dout), .vblank(vblank),
      .mix_we(mix_we), .mix_addr(mix_addr), .mix_data(mix_data), .pending(pending),
      .overflow(overflow), .overflow_clr(overflow_clr), .draining(draining));
   always #5 clk = ~clk;
   logic [11:0] q[$];
   logic [7:0]  sh [16];
   int          left, tests, fails;
   bit          pvbl, e_we, e_ovf;
   logic [3:0]  e_addr;
   logic [7:0]  e_data;
   logic [15:0] e_dout;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      q.delete();
      foreach (sh[i]) sh[i] = 8'h00;
      left = 0; pvbl = 0; e_we = 0; e_ovf = 0; e_addr = 0; e_data = 0; e_dout = 0;
   endtask
   task automatic step(input bit c, input bit rw, input logic [3:0] a, input logic [15:0] d,
                       input logic [1:0] ds, input bit vb, input bit clr);
      bit wr, pop, rise, drop;
      cs = c; cpu_rw = rw; cpu_addr = a; cpu_din = d; cpu_ds_n = ds; vblank = vb; overflow_clr = clr;
      @(posedge clk);
      wr   = c && !rw && !ds[0];
      pop  = left > 0;
      rise = vb && !pvbl;
      pvbl = vb;
      e_we = pop;
      if (pop) begin
         {e_addr, e_data} = q.pop_front();
         left--;
      end else if (rise) left = q.size();
      drop = wr && q.size() >= DEPTH;
      if (wr) begin
         sh[a] = d[7:0];
         if (!drop) q.push_back({a, d[7:0]});
      end
      if (drop) e_ovf = 1;
      else if (clr) e_ovf = 0;
      if (c && rw) e_dout = {sh[a], sh[a]};
      #1;
      check("mix_we", mix_we, e_we);
      check("mix_addr", mix_addr, e_addr);
      check("mix_data", mix_data, e_data);
      check("pending", pending, q.size());
      check("overflow", overflow, e_ovf);
      check("draining", draining, left > 0);
      check("cpu_dout", cpu_dout, e_dout);
   endtask
   task automatic wr(input logic [3:0] a, input logic [15:0] d, input bit vb = 0);
      step(1, 0, a, d, 2'b00, vb, 0);
   endtask
   task automatic rd(input logic [3:0] a);
      step(1, 1, a, 16'h0, 2'b11, 0, 0);
   endtask
   task automatic idle(input int n, input bit vb);
      for (int i = 0; i < n; i++) step(0, 1, 0, 0, 2'b11, vb, 0);
   endtask
   initial begin
      model_reset();
      tests = 0; fails = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pending", pending, 0);
      check("rst_mix_we", mix_we, 0);
      check("rst_dout", cpu_dout, 0);
      check("rst_overflow", overflow, 0);
      check("rst_draining", draining, 0);
      @(negedge clk) reset_n = 1;
      @(posedge clk); #1;
      wr(4, 16'h0021); wr(5, 16'h0043);
      idle(3, 0);
      check("two_pending", pending, 2);
      rd(4); check("rd4", cpu_dout, 16'h2121);
      rd(5); check("rd5", cpu_dout, 16'h4343);
      idle(6, 1); idle(2, 0);
      check("drained", pending, 0);
      for (int i = 0; i < 10; i++) wr(4'(i), 16'(16'h10 + i));
      check("ovf_pending", pending, 8);
      check("ovf_set", overflow, 1);
      rd(9); check("rd9", cpu_dout, 16'h1919);
      idle(12, 1); idle(2, 0);
      step(0, 1, 0, 0, 2'b11, 0, 1);
      check("ovf_clr", overflow, 0);
      wr(2, 16'h0a); wr(3, 16'h0b); wr(7, 16'h0c);
      idle(1, 1);
      wr(1, 16'h00c0, 1);
      idle(5, 1); idle(2, 0);
      check("late_pending", pending, 1);
      idle(4, 1); idle(2, 0);
      wr(6, 16'h0077);
      step(1, 0, 6, 16'h5555, 2'b01, 0, 0);
      check("ds_ignored", pending, 1);
      rd(6); check("rd6", cpu_dout, 16'h7777);
      idle(4, 1); idle(2, 0);
      for (int i = 0; i < 4; i++) wr(4'(8 + i), 16'(16'hA0 + i));
      idle(2, 1);
      check("mid_drain_we", mix_we, 1);
      @(negedge clk) reset_n = 0;
      #1;
      check("async_we", mix_we, 0);
      check("async_draining", draining, 0);
      check("async_pending", pending, 0);
      model_reset();
      vblank = 0;
      @(negedge clk) reset_n = 1;
      for (int i = 0; i < 16; i++) begin
         rd(4'(i));
         check("rst_shadow", cpu_dout, 0);
      end
      for (int cyc = 0; cyc < 600; cyc++)
         step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, 4'($urandom),
              16'($urandom), 2'($urandom_range(0, 4) == 0 ? 2'b01 : 2'b10),
              (cyc % 40) >= 30, $urandom_range(0, 15) == 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
